// File: rtl/pcore_ctrl_if.sv
// ============================================================================
// pcore_ctrl_if : request, result and pcore-side signals of pcore_ctrl
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface pcore_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [0:63]      in_data;
  logic [0:127]     in_key;
  logic             in_dec;

  logic             core_st;
  logic             core_d;
  logic [0:63]      core_inp;
  logic [0:127]     core_key;
  logic [0:63]      core_out;

  logic             out_valid;
  logic             out_ready;
  logic [0:63]      out_data;
  logic             out_dec;
  logic [CNT_W-1:0] blk_cnt;

  modport slave (
    input  in_valid, in_data, in_key, in_dec, core_out, out_ready,
    output in_ready, core_st, core_d, core_inp, core_key,
           out_valid, out_data, out_dec, blk_cnt
  );

  modport master (
    output in_valid, in_data, in_key, in_dec, core_out, out_ready,
    input  in_ready, core_st, core_d, core_inp, core_key,
           out_valid, out_data, out_dec, blk_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pcore_ctrl.sv
// ============================================================================
// pcore_ctrl : request/result sequencer around the fixed-latency PRINCE core
// Revision   : 1.0
// ============================================================================
`default_nettype none

module pcore_ctrl #(
  parameter int CORE_LAT = 12,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  pcore_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] C_LAT_M1 = 8'(CORE_LAT - 1);

  state_t           r_state;
  logic [7:0]       r_lat;
  logic             r_in_ready;
  logic             r_st;
  logic             r_d;
  logic [0:63]      r_inp;
  logic [0:127]     r_key;
  logic             r_out_valid;
  logic [0:63]      r_out_data;
  logic             r_out_dec;
  logic [CNT_W-1:0] r_cnt;

  // While holding a result the next request may enter on the same edge it drains
  assign bus.in_ready  = (r_state == HOLD) ? bus.out_ready : r_in_ready;
  assign bus.core_st   = r_st;
  assign bus.core_d    = r_d;
  assign bus.core_inp  = r_inp;
  assign bus.core_key  = r_key;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_dec   = r_out_dec;
  assign bus.blk_cnt   = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lat       <= 8'd0;
      r_in_ready  <= 1'b1;
      r_st        <= 1'b0;
      r_d         <= 1'b0;
      r_inp       <= '0;
      r_key       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_dec   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_inp      <= bus.in_data;
            r_key      <= bus.in_key;
            r_d        <= bus.in_dec;
            r_st       <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          r_st    <= 1'b0;
          r_lat   <= C_LAT_M1;
          r_state <= RUN;
        end
        RUN: begin
          // Counter reaches zero on the edge where pcore.out holds the result
          if (r_lat == 8'd0) begin
            r_out_data  <= bus.core_out;
            r_out_dec   <= r_d;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_lat <= r_lat - 8'd1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_cnt       <= r_cnt + CNT_W'(1);
            if (bus.in_valid) begin
              r_inp   <= bus.in_data;
              r_key   <= bus.in_key;
              r_d     <= bus.in_dec;
              r_st    <= 1'b1;
              r_state <= START;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcore_ctrl.sv
// ============================================================================
// tb_pcore_ctrl : randomized and directed bench for pcore_ctrl with a pcore stand-in
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_pcore_ctrl;

  localparam int CORE_LAT = 12;
  localparam int CNT_W    = 4;

  localparam logic [0:127] C_K3 = 128'h0000000000000000fedcba9876543210;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pcore_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pcore_ctrl #(.CORE_LAT(CORE_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Known PRINCE answers; any other block maps through a keyed mixing function
  function automatic logic [0:63] ref_core(input logic [0:63] d, input logic [0:127] k,
                                            input logic dec);
    if (!dec && d == 64'h0 && k == 128'h0)                  return 64'h818665aa0d02dfda;
    if ( dec && d == 64'h818665aa0d02dfda && k == 128'h0)   return 64'h0000000000000000;
    if (!dec && d == 64'h0123456789abcdef && k == C_K3)     return 64'hae25ad3ca8fa9ccf;
    if ( dec && d == 64'hae25ad3ca8fa9ccf && k == C_K3)     return 64'h0123456789abcdef;
    return {d[8:63], d[0:7]} ^ k[0:63] ^ {k[96:127], k[64:95]}
           ^ (dec ? 64'h5a5a_c3c3_0f0f_9696 : 64'h1234_5678_9abc_def0);
  endfunction

  // pcore stand-in: result is only valid on the exact capture edge
  int          core_cnt = 0;
  logic [0:63] core_res = '0;

  always @(posedge clk) begin
    if (bus.core_st) begin
      core_res <= ref_core(bus.core_inp, bus.core_key, bus.core_d);
      core_cnt <= CORE_LAT;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign bus.core_out = (core_cnt == 1) ? core_res : ~core_res;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: queue of accepted blocks and the block count
  typedef struct {
    logic [0:63]  d;
    logic [0:127] k;
    logic         dec;
    int           acc;
  } req_t;

  req_t             pend[$];
  logic [CNT_W-1:0] m_cnt    = '0;
  logic [0:63]      last_d   = '0;
  logic [0:127]     last_k   = '0;
  logic             last_dec = 1'b0;
  int               last_acc = -10;
  logic             prev_ov  = 1'b0;
  logic             prev_hs  = 1'b0;
  logic [0:63]      prev_od  = '0;
  bit               will_acc = 1'b0;
  bit               saw15    = 1'b0;
  bit               saw_wrap = 1'b0;

  always @(negedge clk) begin
    bit   hs_i, hs_o;
    bit   exp_ov;
    req_t r;
    if (rst) begin
      pend.delete();
      m_cnt    = '0;
      last_d   = '0;
      last_k   = '0;
      last_dec = 1'b0;
      last_acc = -10;
      prev_ov  = 1'b0;
      prev_hs  = 1'b0;
      will_acc = 1'b0;
    end else begin
      exp_ov = (pend.size() > 0) && (cyc >= pend[0].acc + CORE_LAT + 1);
      check("out_valid", bus.out_valid, exp_ov);
      check("in_ready", bus.in_ready, bus.out_valid ? bus.out_ready : (pend.size() == 0));
      check("core_st", bus.core_st, cyc == last_acc);
      check("core_inp", bus.core_inp, last_d);
      check("core_key", bus.core_key, last_k);
      check("core_d", bus.core_d, last_dec);
      check("blk_cnt", bus.blk_cnt, m_cnt);
      if (bus.out_valid && prev_ov && !prev_hs)
        check("out_hold", bus.out_data, prev_od);
      if (bus.out_valid && pend.size() > 0) begin
        check("out_data", bus.out_data, ref_core(pend[0].d, pend[0].k, pend[0].dec));
        check("out_dec", bus.out_dec, pend[0].dec);
      end

      hs_o = bus.out_valid && bus.out_ready;
      hs_i = bus.in_valid && bus.in_ready;
      if (hs_o) begin
        if (pend.size() > 0) void'(pend.pop_front());
        m_cnt = m_cnt + 1'b1;
        if (m_cnt == '1) saw15 = 1'b1;
        if (m_cnt == '0 && saw15) saw_wrap = 1'b1;
      end
      if (hs_i) begin
        r.d = bus.in_data; r.k = bus.in_key; r.dec = bus.in_dec; r.acc = cyc + 1;
        pend.push_back(r);
        last_d = bus.in_data; last_k = bus.in_key; last_dec = bus.in_dec;
        last_acc = cyc + 1;
      end
      will_acc = hs_i;
      prev_ov  = bus.out_valid;
      prev_od  = bus.out_data;
      prev_hs  = hs_o;
    end
  end

  // Present a request and return the edge index at which it was accepted
  task automatic send(input logic [0:63] d, input logic [0:127] k, input logic dec,
                      output int acc);
    bit ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_key = k; bus.in_dec = dec;
    acc = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; acc = cyc + 1; end
    end
    check("accept_seen", ok, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int at);
    bit ok = 1'b0;
    at = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1'b1; at = cyc; end
    end
    check("out_seen", ok, 1'b1);
  endtask

  task automatic pick_request();
    int sel = $urandom_range(0, 5);
    case (sel)
      0: begin bus.in_data = 64'h0;                bus.in_key = 128'h0; bus.in_dec = 1'b0; end
      1: begin bus.in_data = 64'h818665aa0d02dfda; bus.in_key = 128'h0; bus.in_dec = 1'b1; end
      2: begin bus.in_data = 64'h0123456789abcdef; bus.in_key = C_K3;   bus.in_dec = 1'b0; end
      default: begin
        bus.in_data = {$urandom, $urandom};
        bus.in_key  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_dec  = 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  initial begin
    int acc, at, hs;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.in_dec    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_core_st", bus.core_st, 1'b0);
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_blk_cnt", bus.blk_cnt, 0);
    rst = 1'b0;

    // Known-answer encrypt/decrypt round trips
    bus.out_ready = 1'b1;
    send(64'h0, 128'h0, 1'b0, acc);
    wait_out(at);
    check("lat_enc0", at - acc, CORE_LAT + 1);
    check("kat_enc0", bus.out_data, 64'h818665aa0d02dfda);
    send(64'h818665aa0d02dfda, 128'h0, 1'b1, acc);
    wait_out(at);
    check("kat_dec0", bus.out_data, 64'h0);
    check("kat_dec0_mode", bus.out_dec, 1'b1);
    send(64'h0123456789abcdef, C_K3, 1'b0, acc);
    wait_out(at);
    check("kat_enc3", bus.out_data, 64'hae25ad3ca8fa9ccf);
    send(64'hae25ad3ca8fa9ccf, C_K3, 1'b1, acc);
    wait_out(at);
    check("kat_dec3", bus.out_data, 64'h0123456789abcdef);

    // Backpressure, then simultaneous output and input handshake
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(64'h0, 128'h0, 1'b0, acc);
    wait_out(at);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 64'h0123456789abcdef; bus.in_key = C_K3; bus.in_dec = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("bp_in_ready", bus.in_ready, 1'b0);
    check("bp_out_data", bus.out_data, 64'h818665aa0d02dfda);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("same_edge_hs", {bus.in_valid & bus.in_ready, bus.out_valid & bus.out_ready}, 2'b11);
    acc = cyc + 1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(at);
    check("lat_b2b", at - acc, CORE_LAT + 1);
    check("kat_b2b", bus.out_data, 64'hae25ad3ca8fa9ccf);

    // Asynchronous reset in the middle of a run
    @(posedge clk); #1;
    send(64'h0, 128'h0, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_core_st", bus.core_st, 1'b0);
    check("mid_rst_blk_cnt", bus.blk_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (CORE_LAT + 3) @(negedge clk);
    check("no_stale_out", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    send(64'h0, 128'h0, 1'b0, acc);
    wait_out(at);
    check("post_rst_kat", bus.out_data, 64'h818665aa0d02dfda);
    @(negedge clk);
    check("post_rst_cnt", bus.blk_cnt, 1);

    // Back-to-back burst past the counter wrap
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    pick_request();
    hs = 0;
    for (int c = 0; c < 17 * (CORE_LAT + 4) && hs < 17; c++) begin
      @(posedge clk); #1;
      if (will_acc) begin hs++; pick_request(); end
    end
    bus.in_valid = 1'b0;
    check("burst_count", hs, 17);

    // Random valid/ready traffic
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || will_acc) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        pick_request();
      end
    end

    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2 * CORE_LAT + 6) @(posedge clk);
    @(negedge clk);
    check("drained", pend.size(), 0);
    check("cnt_wrapped", saw_wrap, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcore_ctrl.md
Name: pcore_ctrl

Overview:
- Upstream/downstream sequencer for the round-based PRINCE core `pcore`.
- Accepts encrypt/decrypt requests over a valid/ready interface and registers data, key and mode.
- Issues a one-cycle `st` pulse to `pcore`, counts the core's fixed latency, captures `pcore.out`, and presents it on a buffered valid/ready result interface with a completed-block counter.

Parameters:
- CORE_LAT, 12: cycles from the clock edge at which pcore samples st=1 to the edge at which pcore.out holds the result; legal range 1..255.
- CNT_W, 16: width of blk_cnt.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready at clk edge
- in_data  in  [0:63]  plaintext/ciphertext
- in_key  in  [0:127]  key
- in_dec  in  1  1=decrypt, 0=encrypt
- core_st  out  1  to pcore.st
- core_d  out  1  to pcore.d
- core_inp  out  [0:63]  to pcore.inp
- core_key  out  [0:127]  to pcore.key
- core_out  in  [0:63]  from pcore.out
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready at clk edge
- out_data  out  [0:63]  result
- out_dec  out  1  mode of returned block
- blk_cnt  out  [CNT_W-1:0]  completed output handshakes, wraps

Behaviour:
- All outputs registered. Reset values:
  - in_ready=1, core_st=0, core_d=0, core_inp=0, core_key=0.
  - out_valid=0, out_data=0, out_dec=0, blk_cnt=0, state=IDLE, lat counter=0.
- FSM states: IDLE, START, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On accept at edge t: load core_inp/core_key/core_d from inputs, core_st<=1, in_ready<=0, go to START.
- START:
  - core_st is high for exactly one cycle, so pcore samples st=1 at edge t+1.
  - At t+1: core_st<=0, counter<=CORE_LAT-1, go to RUN.
  - If CORE_LAT=1, go directly to the capture action below at t+2.
- RUN:
  - Counter decrements each edge.
  - At edge t+1+CORE_LAT, capture out_data<=core_out and out_dec<=core_d; set out_valid<=1 and go to HOLD.
  - Accept-to-out_valid latency is CORE_LAT+1 cycles.
- core_inp, core_key and core_d are held stable from load until the next accept; they never change during START/RUN.
- HOLD:
  - out_valid=1; out_data/out_dec are held stable until handshake.
  - in_ready is combinationally equal to out_ready while in HOLD; this is the only non-registered path.
  - out_ready=1 and in_valid=0: out_valid<=0, in_ready<=1, go to IDLE.
  - out_ready=1 and in_valid=1 (simultaneous): complete output handshake and accept the new request in the same edge; next state START, so there are no bubbles beyond the core latency.
  - out_ready=0: stay in HOLD, no accept.
- blk_cnt increments by 1 on each output handshake and wraps from all-ones to 0.
- in_valid during START/RUN is ignored (in_ready=0); requesters hold their data.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-operation (any state) immediately forces reset values. The in-flight block is discarded with no out_valid, and pcore's internal state is ignored. After deassertion the block starts in IDLE.
- No X propagation: out_data only updates at capture.

Test Plan:
1. Encrypt, zero data: in_data=0, in_key=0, in_dec=0, out_ready=1 → out_valid exactly CORE_LAT+1 cycles after accept; out_data=818665aa0d02dfda, out_dec=0, blk_cnt=1.
2. Decrypt, zero key: in_data=818665aa0d02dfda, in_key=0, in_dec=1 → out_data=0000000000000000, out_dec=1; core_st high exactly one cycle; core_inp stable throughout RUN.
3. Encrypt with non-zero key: in_data=0123456789abcdef, in_key=0000000000000000fedcba9876543210, enc → out_data=ae25ad3ca8fa9ccf. Then decrypt ae25ad3ca8fa9ccf with the same key → 0123456789abcdef.
4. Backpressure: out_ready=0 for 10 cycles after out_valid → out_data held constant, in_ready=0, a second in_valid is not accepted. Raise out_ready together with in_valid → output and input handshakes occur on the same edge; the second result appears CORE_LAT+1 cycles later.
5. Reset mid-RUN: assert rst 3 cycles after accept → in_ready=1, out_valid=0, core_st=0 immediately. After release, a fresh zero-vector encrypt returns 818665aa0d02dfda and blk_cnt counts from 1.
6. Counter wrap with CNT_W=4: 17 back-to-back handshakes → blk_cnt sequence reaches 15, then 0, then 1.
